// File: rtl/mmu_ctrl_n_pkg.sv
// Shared types for the matrix-multiply controller: FSM state encoding and
// accumulator width helper used by both the controller and the array.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ctrl_state_e;

    function automatic int acc_w(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/mmu_ctrl_n_if.sv
// Host-side load/read bus of the matrix-multiply controller.
interface mmu_ctrl_n_if #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int OW = 8
);
    localparam int IW = $clog2(N * N);

    logic          load_en;
    logic          load_sel_ab;
    logic [IW-1:0] load_index;
    logic [DW-1:0] in_data;
    logic          load_ready;
    logic          start;
    logic          clear;
    logic          output_en;
    logic [IW-1:0] output_sel;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output load_en, load_sel_ab, load_index, in_data, start, clear, output_en, output_sel,
        input  load_ready, out_data, out_valid, busy, done, err
    );

    modport slave (
        input  load_en, load_sel_ab, load_index, in_data, start, clear, output_en, output_sel,
        output load_ready, out_data, out_valid, busy, done, err
    );
endinterface

// File: rtl/mmu_ctrl_n_array.sv
// NxN multiply array: latches A/B on arr_start, accumulates one k-slice per
// cycle for N cycles, then pulses done with C_flat holding the full sums.
module mmu_array_n
    import tpu_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 8
) (
    input  logic                           clk,
    input  logic                           arr_rst_n,
    input  logic                           arr_start,
    input  logic [N*N*DW-1:0]              A_flat,
    input  logic [N*N*DW-1:0]              B_flat,
    output logic [N*N*acc_w(N, DW)-1:0]    C_flat,
    output logic                           done
);
    localparam int NE    = N * N;
    localparam int ACC_W = acc_w(N, DW);
    localparam int KW    = $clog2(N);

    logic [NE*DW-1:0]    a_q, a_d, b_q, b_d;
    logic [NE*ACC_W-1:0] acc_q, acc_d;
    logic [KW-1:0]       k_q, k_d;
    logic                run_q, run_d, done_q, done_d;
    logic [DW-1:0]       a_el, b_el;
    logic [2*DW-1:0]     prod;
    int unsigned         k;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        k_d    = k_q;
        run_d  = run_q;
        done_d = 1'b0;
        a_el   = '0;
        b_el   = '0;
        prod   = '0;
        k      = 32'(k_q);
        if (arr_start) begin
            a_d   = A_flat;
            b_d   = B_flat;
            acc_d = '0;
            k_d   = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    a_el = a_q[(i*N + k)*DW +: DW];
                    b_el = b_q[(k*N + j)*DW +: DW];
                    prod = (2*DW)'(a_el) * (2*DW)'(b_el);
                    acc_d[(i*N + j)*ACC_W +: ACC_W] = acc_q[(i*N + j)*ACC_W +: ACC_W] + ACC_W'(prod);
                end
            end
            k_d = k_q + 1'b1;
            if (k == N - 1) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Synchronous reset: arr_rst_n is a gated version of the controller reset.
    always_ff @(posedge clk) begin
        if (!arr_rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            k_q    <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            k_q    <= k_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign C_flat = acc_q;
    assign done   = done_q;
endmodule

// File: rtl/mmu_ctrl_n.sv
// Host-side controller for mmu_array_n: operand collection, start control,
// result conversion into a readback bank and registered reads.
module mmu_ctrl_n
    import tpu_pkg::*;
#(
    parameter int N          = 2,
    parameter int DW         = 8,
    parameter int OW         = 8,
    parameter int SATURATE   = 1,
    parameter int AUTO_START = 1
) (
    input logic        clk,
    input logic        rst_n,
    mmu_ctrl_n_if.slave bus
);
    localparam int NE    = N * N;
    localparam int ACC_W = acc_w(N, DW);

    ctrl_state_e         state_q, state_d;
    logic [NE*DW-1:0]    a_q, a_d, b_q, b_d;
    logic [NE-1:0]       a_ld_q, a_ld_d, b_ld_q, b_ld_d;
    logic [NE*OW-1:0]    bank_q, bank_d;
    logic                bank_vld_q, bank_vld_d;
    logic [OW-1:0]       out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                err_q, err_d;
    logic                arr_start_q, arr_start_d;
    logic                arr_rst_n, arr_done, all_loaded, start_go;
    logic [NE*ACC_W-1:0] c_flat;
    int unsigned         ld_i, sel_i;

    function automatic logic [OW-1:0] conv(input logic [ACC_W-1:0] sum);
        logic [ACC_W+OW-1:0] ext;
        ext = (ACC_W+OW)'(sum);
        if (SATURATE != 0 && (ext >> OW) != '0) return '1;
        return ext[OW-1:0];
    endfunction

    assign all_loaded = (&a_ld_q) & (&b_ld_q);
    assign start_go   = (AUTO_START != 0) ? all_loaded : (bus.start & all_loaded);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        a_ld_d      = a_ld_q;
        b_ld_d      = b_ld_q;
        bank_d      = bank_q;
        bank_vld_d  = bank_vld_q;
        err_d       = err_q;
        arr_start_d = 1'b0;
        out_valid_d = bus.output_en;
        out_data_d  = '0;
        ld_i        = 32'(bus.load_index);
        sel_i       = 32'(bus.output_sel);

        if (bus.output_en) begin
            if (bank_vld_q && sel_i < NE) out_data_d = bank_q[sel_i*OW +: OW];
            else                          err_d      = 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_go) begin
                    arr_start_d = 1'b1;
                    a_ld_d      = '0;
                    b_ld_d      = '0;
                    state_d     = RUN;
                end else if (AUTO_START == 0 && bus.start) begin
                    err_d = 1'b1;
                end
                if (bus.load_en) begin
                    if (ld_i < NE) begin
                        if (bus.load_sel_ab) begin
                            b_d[ld_i*DW +: DW] = bus.in_data;
                            b_ld_d[ld_i]       = 1'b1;
                        end else begin
                            a_d[ld_i*DW +: DW] = bus.in_data;
                            a_ld_d[ld_i]       = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.load_en) err_d = 1'b1;
                if (arr_done) begin
                    for (int unsigned e = 0; e < NE; e++)
                        bank_d[e*OW +: OW] = conv(c_flat[e*ACC_W +: ACC_W]);
                    bank_vld_d = 1'b1;
                    state_d    = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // clear overrides everything decided above, including a same-cycle start or load
        if (bus.clear) begin
            state_d     = IDLE;
            a_ld_d      = '0;
            b_ld_d      = '0;
            bank_vld_d  = 1'b0;
            err_d       = 1'b0;
            arr_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            a_ld_q      <= '0;
            b_ld_q      <= '0;
            bank_q      <= '0;
            bank_vld_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            arr_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            a_ld_q      <= a_ld_d;
            b_ld_q      <= b_ld_d;
            bank_q      <= bank_d;
            bank_vld_q  <= bank_vld_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            arr_start_q <= arr_start_d;
        end
    end

    assign arr_rst_n = rst_n & ~(bus.clear & (state_q == RUN));

    mmu_array_n #(.N(N), .DW(DW)) u_array (
        .clk       (clk),
        .arr_rst_n (arr_rst_n),
        .arr_start (arr_start_q),
        .A_flat    (a_q),
        .B_flat    (b_q),
        .C_flat    (c_flat),
        .done      (arr_done)
    );

    assign bus.load_ready = (state_q != RUN);
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_mmu_ctrl_n.sv
// Directed bench for mmu_ctrl_n: saturating, truncating, manual-start (N=2)
// and N=3 instances driven from shared host stimulus.
module tb_mmu_ctrl_n;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic       g_ld_en, g_sel, g_start, g_clear, g_oen;
    logic [1:0] g_idx, g_osel;
    logic [7:0] g_din;
    logic       t_ld_en, t_sel, t_clear, t_oen;
    logic [3:0] t_idx, t_osel;
    logic [7:0] t_din;

    mmu_ctrl_n_if #(.N(2), .DW(8), .OW(8)) if_sat ();
    mmu_ctrl_n_if #(.N(2), .DW(8), .OW(8)) if_trn ();
    mmu_ctrl_n_if #(.N(2), .DW(8), .OW(8)) if_man ();
    mmu_ctrl_n_if #(.N(3), .DW(8), .OW(8)) if_n3 ();

    assign if_sat.load_en = g_ld_en;  assign if_sat.load_sel_ab = g_sel;  assign if_sat.load_index = g_idx;
    assign if_sat.in_data = g_din;    assign if_sat.start = g_start;      assign if_sat.clear = g_clear;
    assign if_sat.output_en = g_oen;  assign if_sat.output_sel = g_osel;
    assign if_trn.load_en = g_ld_en;  assign if_trn.load_sel_ab = g_sel;  assign if_trn.load_index = g_idx;
    assign if_trn.in_data = g_din;    assign if_trn.start = g_start;      assign if_trn.clear = g_clear;
    assign if_trn.output_en = g_oen;  assign if_trn.output_sel = g_osel;
    assign if_man.load_en = g_ld_en;  assign if_man.load_sel_ab = g_sel;  assign if_man.load_index = g_idx;
    assign if_man.in_data = g_din;    assign if_man.start = g_start;      assign if_man.clear = g_clear;
    assign if_man.output_en = g_oen;  assign if_man.output_sel = g_osel;
    assign if_n3.load_en = t_ld_en;   assign if_n3.load_sel_ab = t_sel;   assign if_n3.load_index = t_idx;
    assign if_n3.in_data = t_din;     assign if_n3.start = 1'b0;          assign if_n3.clear = t_clear;
    assign if_n3.output_en = t_oen;   assign if_n3.output_sel = t_osel;

    mmu_ctrl_n #(.N(2), .DW(8), .OW(8), .SATURATE(1), .AUTO_START(1)) u_sat (.clk(clk), .rst_n(rst_n), .bus(if_sat.slave));
    mmu_ctrl_n #(.N(2), .DW(8), .OW(8), .SATURATE(0), .AUTO_START(1)) u_trn (.clk(clk), .rst_n(rst_n), .bus(if_trn.slave));
    mmu_ctrl_n #(.N(2), .DW(8), .OW(8), .SATURATE(1), .AUTO_START(0)) u_man (.clk(clk), .rst_n(rst_n), .bus(if_man.slave));
    mmu_ctrl_n #(.N(3), .DW(8), .OW(8), .SATURATE(1), .AUTO_START(1)) u_n3  (.clk(clk), .rst_n(rst_n), .bus(if_n3.slave));

    typedef struct {
        int a[4];
        int b[4];
        int sat[4];
        int trn[4];
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic flag(input int which);
        case (which)
            0:       return if_sat.busy;
            1:       return if_sat.done;
            2:       return if_man.busy;
            3:       return if_man.done;
            default: return if_n3.done;
        endcase
    endfunction

    task automatic wait_flag(input string name, input int which);
        int cyc = 0;
        while (!flag(which) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk(name, int'(flag(which)), 1);
    endtask

    task automatic load2(input logic sel, input int idx, input int val);
        g_ld_en = 1'b1; g_sel = sel; g_idx = 2'(idx); g_din = 8'(val);
        @(negedge clk);
        g_ld_en = 1'b0;
    endtask

    task automatic load_vec(input int v);
        for (int i = 0; i < 4; i++) load2(1'b0, i, vecs[v].a[i]);
        for (int i = 0; i < 4; i++) load2(1'b1, i, vecs[v].b[i]);
    endtask

    task automatic read2(input int sel);
        g_oen = 1'b1; g_osel = 2'(sel);
        @(negedge clk);
        g_oen = 1'b0;
    endtask

    task automatic load3(input logic sel, input int idx, input int val);
        t_ld_en = 1'b1; t_sel = sel; t_idx = 4'(idx); t_din = 8'(val);
        @(negedge clk);
        t_ld_en = 1'b0;
    endtask

    task automatic read3(input int sel);
        t_oen = 1'b1; t_osel = 4'(sel);
        @(negedge clk);
        t_oen = 1'b0;
    endtask

    task automatic pulse_clear();
        g_clear = 1'b1;
        @(negedge clk);
        g_clear = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        vecs[0].a = '{1, 2, 3, 4};         vecs[0].b = '{5, 6, 7, 8};
        vecs[0].sat = '{19, 22, 43, 50};   vecs[0].trn = '{19, 22, 43, 50};
        vecs[1].a = '{255, 255, 255, 255}; vecs[1].b = '{255, 255, 255, 255};
        vecs[1].sat = '{255, 255, 255, 255}; vecs[1].trn = '{2, 2, 2, 2};
        vecs[2].a = '{10, 0, 0, 10};       vecs[2].b = '{20, 30, 1, 2};
        vecs[2].sat = '{200, 255, 10, 20}; vecs[2].trn = '{200, 44, 10, 20};
        vecs[3].a = '{0, 1, 1, 0};         vecs[3].b = '{3, 4, 5, 6};
        vecs[3].sat = '{5, 6, 3, 4};       vecs[3].trn = '{5, 6, 3, 4};

        g_ld_en = 0; g_sel = 0; g_idx = 0; g_din = 0; g_start = 0; g_clear = 0; g_oen = 0; g_osel = 0;
        t_ld_en = 0; t_sel = 0; t_idx = 0; t_din = 0; t_clear = 0; t_oen = 0; t_osel = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_load_ready", int'(if_sat.load_ready), 1);
        chk("rst_busy", int'(if_sat.busy), 0);
        chk("rst_done", int'(if_sat.done), 0);
        chk("rst_err", int'(if_sat.err), 0);
        chk("rst_out_valid", int'(if_sat.out_valid), 0);
        chk("rst_out_data", int'(if_sat.out_data), 0);

        read2(2);
        chk("early_read_valid", int'(if_sat.out_valid), 1);
        chk("early_read_data", int'(if_sat.out_data), 0);
        chk("early_read_err", int'(if_sat.err), 1);
        pulse_clear();
        chk("clear_err", int'(if_sat.err), 0);

        for (int v = 0; v < 4; v++) begin
            load_vec(v);
            wait_flag($sformatf("v%0d_busy", v), 0);
            chk($sformatf("v%0d_trn_busy", v), int'(if_trn.busy), 1);
            chk($sformatf("v%0d_load_ready", v), int'(if_sat.load_ready), 0);
            wait_flag($sformatf("v%0d_done", v), 1);
            chk($sformatf("v%0d_trn_done", v), int'(if_trn.done), 1);
            for (int e = 0; e < 4; e++) begin
                read2(e);
                chk($sformatf("v%0d_sat_c%0d", v, e), int'(if_sat.out_data), vecs[v].sat[e]);
                chk($sformatf("v%0d_trn_c%0d", v, e), int'(if_trn.out_data), vecs[v].trn[e]);
                chk($sformatf("v%0d_valid_c%0d", v, e), int'(if_sat.out_valid), 1);
            end
        end
        chk("table_err", int'(if_sat.err), 0);

        load_vec(0);
        wait_flag("run_load_busy", 0);
        chk("run_load_ready", int'(if_sat.load_ready), 0);
        load2(1'b0, 0, 99);
        chk("run_load_err", int'(if_sat.err), 1);
        wait_flag("run_load_done", 1);
        for (int e = 0; e < 4; e++) begin
            read2(e);
            chk($sformatf("run_load_c%0d", e), int'(if_sat.out_data), vecs[0].sat[e]);
        end
        pulse_clear();
        chk("run_load_clear_err", int'(if_sat.err), 0);

        load_vec(0);
        wait_flag("abort_busy", 0);
        pulse_clear();
        chk("abort_busy_low", int'(if_sat.busy), 0);
        chk("abort_done_low", int'(if_sat.done), 0);
        chk("abort_err", int'(if_sat.err), 0);
        chk("abort_load_ready", int'(if_sat.load_ready), 1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (if_sat.done || if_sat.busy) seen = 1;
        end
        chk("abort_no_done", seen, 0);

        pulse_clear();
        for (int i = 0; i < 4; i++) load2(1'b0, i, vecs[0].a[i]);
        g_start = 1'b1;
        @(negedge clk);
        g_start = 1'b0;
        chk("man_half_err", int'(if_man.err), 1);
        chk("man_half_busy", int'(if_man.busy), 0);
        for (int i = 0; i < 4; i++) load2(1'b1, i, vecs[0].b[i]);
        repeat (3) @(negedge clk);
        chk("man_no_auto", int'(if_man.busy), 0);
        g_start = 1'b1;
        @(negedge clk);
        g_start = 1'b0;
        wait_flag("man_busy", 2);
        wait_flag("man_done", 3);
        read2(3);
        chk("man_c3", int'(if_man.out_data), 50);
        read2(0);
        chk("man_c0", int'(if_man.out_data), 19);
        chk("man_err_sticky", int'(if_man.err), 1);

        pulse_clear();
        load_vec(0);
        wait_flag("ares_busy", 0);
        read2(0);
        chk("ares_pre_err", int'(if_sat.err), 1);
        chk("ares_pre_valid", int'(if_sat.out_valid), 1);
        chk("ares_pre_busy", int'(if_sat.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ares_busy", int'(if_sat.busy), 0);
        chk("ares_load_ready", int'(if_sat.load_ready), 1);
        chk("ares_err", int'(if_sat.err), 0);
        chk("ares_valid", int'(if_sat.out_valid), 0);
        chk("ares_man_err", int'(if_man.err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_vec(3);
        wait_flag("ares_reload_done", 1);
        for (int e = 0; e < 4; e++) begin
            read2(e);
            chk($sformatf("ares_reload_c%0d", e), int'(if_sat.out_data), vecs[3].sat[e]);
        end

        for (int i = 0; i < 9; i++) load3(1'b0, i, i + 1);
        for (int i = 0; i < 8; i++) load3(1'b1, i, (i % 4 == 0) ? 1 : 0);
        load3(1'b1, 9, 77);
        chk("n3_oob_err", int'(if_n3.err), 1);
        repeat (4) @(negedge clk);
        chk("n3_no_start", int'(if_n3.busy), 0);
        load3(1'b1, 8, 1);
        wait_flag("n3_done", 4);
        read3(4);
        chk("n3_c4", int'(if_n3.out_data), 5);
        read3(8);
        chk("n3_c8", int'(if_n3.out_data), 9);
        read3(9);
        chk("n3_oob_read_data", int'(if_n3.out_data), 0);
        chk("n3_oob_read_valid", int'(if_n3.out_valid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
